hidden_layer_seq: RTL and testbench

Time-multiplexing controller for a single `hidden_neuron` datapath instance.
- Holds a weight table for NUM_NEURONS neurons and accepts one 4-bit input sample through a valid/ready handshake.
- Drives the shared neuron (`x`, `w0..w3`, `en`) once per neuron on consecutive cycles and captures each registered result.
- Presents all results together on a valid/ready output.
- Sits between the chip I/O configuration/sample path and the output layer, so one physical neuron serves the whole hidden layer.

---
 rtl/hidden_layer_seq_if.sv | 38 +++
 rtl/hidden_layer_seq.sv | 158 +++++++++++++++
 tb/tb_hidden_layer_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/hidden_layer_seq_if.sv
// Bus bundle between the hidden-layer sequencer, its environment and the shared neuron.
interface hidden_layer_seq_if #(
  parameter int unsigned NUM_NEURONS = 4
) ();
  localparam int unsigned RES_W = 10 * NUM_NEURONS;

  logic             cfg_start_i;
  logic             cfg_valid_i;
  logic [7:0]       cfg_data_i;
  logic             cfg_ready_o;
  logic             x_valid_i;
  logic [3:0]       x_i;
  logic             x_ready_o;
  logic [3:0]       nx_o;
  logic [7:0]       nw0_o;
  logic [7:0]       nw1_o;
  logic [7:0]       nw2_o;
  logic [7:0]       nw3_o;
  logic             nen_o;
  logic [9:0]       nh_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [RES_W-1:0] res_o;

  // Environment side: configuration source, sample source, result sink and neuron.
  modport master (
    output cfg_start_i, cfg_valid_i, cfg_data_i, x_valid_i, x_i, nh_i, res_ready_i,
    input  cfg_ready_o, x_ready_o, nx_o, nw0_o, nw1_o, nw2_o, nw3_o, nen_o,
           res_valid_o, res_o
  );

  // Sequencer side.
  modport slave (
    input  cfg_start_i, cfg_valid_i, cfg_data_i, x_valid_i, x_i, nh_i, res_ready_i,
    output cfg_ready_o, x_ready_o, nx_o, nw0_o, nw1_o, nw2_o, nw3_o, nen_o,
           res_valid_o, res_o
  );
endinterface

// File: rtl/hidden_layer_seq.sv
// Time-multiplexes one hidden_neuron datapath across NUM_NEURONS logical neurons:
// loads a weight table, sequences one neuron per cycle, collects the results.
module hidden_layer_seq #(
  parameter int unsigned NUM_NEURONS = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  hidden_layer_seq_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned TBL_W = IDX_W + 2;
  localparam int unsigned TBL_N = 4 * NUM_NEURONS;
  localparam int unsigned H_W   = 10;

  localparam logic [TBL_W-1:0] CFG_LAST = TBL_W'(TBL_N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                         state_q;
  logic [TBL_N-1:0][7:0]          tbl_q;
  logic [TBL_W-1:0]               cfg_cnt_q;
  logic [IDX_W-1:0]               idx_q;
  logic [IDX_W-1:0]               idx_inc;
  logic [3:0]                     x_q;
  logic                           cfg_ready_q;
  logic                           x_ready_q;
  logic [3:0]                     nx_q;
  logic [3:0][7:0]                nw_q;
  logic [3:0][7:0]                w_nxt;
  logic                           nen_q;
  logic                           res_valid_q;
  logic                           cap_en_q;
  logic [IDX_W-1:0]               cap_idx_q;
  logic [NUM_NEURONS-1:0][H_W-1:0] res_q;

  // Weights of the neuron that follows the one currently on the bus.
  always_comb begin
    idx_inc = idx_q + IDX_W'(1);
    w_nxt   = '0;
    for (int k = 0; k < 4; k++) begin
      w_nxt[k] = tbl_q[{idx_inc, 2'(k)}];
    end
  end

  // Control FSM with its registered outputs and the weight table.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_CFG;
      tbl_q       <= '0;
      cfg_cnt_q   <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      cfg_ready_q <= 1'b1;
      x_ready_q   <= 1'b0;
      nx_q        <= '0;
      nw_q        <= '0;
      nen_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_CFG: begin
          if (bus.cfg_valid_i) begin
            tbl_q[cfg_cnt_q] <= bus.cfg_data_i;
            if (cfg_cnt_q == CFG_LAST) begin
              cfg_cnt_q   <= '0;
              state_q     <= S_IDLE;
              cfg_ready_q <= 1'b0;
              x_ready_q   <= 1'b1;
            end else begin
              cfg_cnt_q <= cfg_cnt_q + TBL_W'(1);
            end
          end
        end
        S_IDLE: begin
          // A sample takes priority over a configuration restart.
          if (bus.x_valid_i) begin
            x_q       <= bus.x_i;
            idx_q     <= '0;
            state_q   <= S_RUN;
            x_ready_q <= 1'b0;
            nen_q     <= 1'b1;
            nx_q      <= bus.x_i;
            nw_q      <= tbl_q[3:0];
          end else if (bus.cfg_start_i) begin
            cfg_cnt_q   <= '0;
            state_q     <= S_CFG;
            x_ready_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (idx_q == IDX_LAST) begin
            state_q <= S_DRAIN;
            nen_q   <= 1'b0;
            nx_q    <= '0;
            nw_q    <= '0;
          end else begin
            idx_q <= idx_inc;
            nx_q  <= x_q;
            nw_q  <= w_nxt;
          end
        end
        S_DRAIN: begin
          state_q     <= S_DONE;
          res_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (bus.res_ready_i) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            x_ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_CFG;
          cfg_cnt_q   <= '0;
          cfg_ready_q <= 1'b1;
          x_ready_q   <= 1'b0;
          nen_q       <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture the neuron's registered result one cycle after it was driven.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      res_q     <= '0;
    end else begin
      cap_en_q  <= nen_q;
      cap_idx_q <= idx_q;
      if (cap_en_q) begin
        res_q[cap_idx_q] <= bus.nh_i;
      end
    end
  end

  assign bus.cfg_ready_o = cfg_ready_q;
  assign bus.x_ready_o   = x_ready_q;
  assign bus.nx_o        = nx_q;
  assign bus.nw0_o       = nw_q[0];
  assign bus.nw1_o       = nw_q[1];
  assign bus.nw2_o       = nw_q[2];
  assign bus.nw3_o       = nw_q[3];
  assign bus.nen_o       = nen_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_o       = res_q;
endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed bench for hidden_layer_seq with a behavioural hidden_neuron in the loop.
module tb_hidden_layer_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [7:0]  tbl_exp [16];
  logic [9:0]  nh_sum;

  localparam logic [39:0] RES_FULL = {10'd58, 10'd42, 10'd26, 10'd10};
  localparam logic [39:0] RES_PART = {10'd28, 10'd20, 10'd12, 10'd4};

  hidden_layer_seq_if #(.NUM_NEURONS(4)) bus ();

  hidden_layer_seq #(.NUM_NEURONS(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Neuron stand-in: sum of the signed weights whose input bit is set, registered when enabled.
  always_comb begin
    nh_sum = '0;
    if (bus.nx_o[0]) nh_sum = nh_sum + {{2{bus.nw0_o[7]}}, bus.nw0_o};
    if (bus.nx_o[1]) nh_sum = nh_sum + {{2{bus.nw1_o[7]}}, bus.nw1_o};
    if (bus.nx_o[2]) nh_sum = nh_sum + {{2{bus.nw2_o[7]}}, bus.nw2_o};
    if (bus.nx_o[3]) nh_sum = nh_sum + {{2{bus.nw3_o[7]}}, bus.nw3_o};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.nh_i <= '0;
    else if (bus.nen_o) bus.nh_i <= nh_sum;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready_o), 64'd1);
    chk({tag, "_x_ready"},   64'(bus.x_ready_o),   64'd0);
    chk({tag, "_nen"},       64'(bus.nen_o),       64'd0);
    chk({tag, "_res_valid"}, 64'(bus.res_valid_o), 64'd0);
    chk({tag, "_res"},       64'(bus.res_o),       64'd0);
    chk({tag, "_nw"}, 64'({bus.nw3_o, bus.nw2_o, bus.nw1_o, bus.nw0_o, bus.nx_o}), 64'd0);
  endtask

  // Loads 16 weight bytes (0x01..0x10, or all zero), optionally with idle gaps.
  task automatic load(input bit zero, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = gaps ? int'($urandom_range(2, 1)) : 0;
      repeat (g) begin
        bus.cfg_valid_i = 1'b0;
        bus.cfg_data_i  = 8'($urandom);
        tick();
      end
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = zero ? 8'h00 : 8'(i + 1);
      tbl_exp[i]      = bus.cfg_data_i;
      tick();
    end
    bus.cfg_valid_i = 1'b0;
    bus.cfg_data_i  = 8'h00;
    chk("load_cfg_ready", 64'(bus.cfg_ready_o), 64'd0);
    chk("load_x_ready",   64'(bus.x_ready_o),   64'd1);
  endtask

  // Runs one sample from the IDLE handshake cycle to the first DONE cycle.
  // mode 1: cfg_start with the sample; mode 2: cfg_start pulse in RUN.
  task automatic run_sample(input logic [3:0] x, input logic [39:0] exp, input int mode);
    bus.x_valid_i   = 1'b1;
    bus.x_i         = x;
    bus.cfg_start_i = (mode == 1);
    tick();
    bus.x_valid_i   = 1'b0;
    bus.cfg_start_i = 1'b0;
    if (mode == 1) chk("hs_cfg_ready", 64'(bus.cfg_ready_o), 64'd0);
    for (int j = 0; j < 4; j++) begin
      chk("run_nen", 64'(bus.nen_o), 64'd1);
      chk("run_nx",  64'(bus.nx_o),  64'(x));
      chk("run_nw", 64'({bus.nw3_o, bus.nw2_o, bus.nw1_o, bus.nw0_o}),
          64'({tbl_exp[4*j+3], tbl_exp[4*j+2], tbl_exp[4*j+1], tbl_exp[4*j]}));
      bus.cfg_start_i = (mode == 2 && j == 1);
      tick();
    end
    bus.cfg_start_i = 1'b0;
    chk("drain_nen",       64'(bus.nen_o), 64'd0);
    chk("drain_nw",        64'({bus.nw3_o, bus.nw2_o, bus.nw1_o, bus.nw0_o, bus.nx_o}), 64'd0);
    chk("drain_res_valid", 64'(bus.res_valid_o), 64'd0);
    tick();
    chk("done_res_valid", 64'(bus.res_valid_o), 64'd1);
    chk("done_res",       64'(bus.res_o),       64'(exp));
    chk("done_cfg_ready", 64'(bus.cfg_ready_o), 64'd0);
    chk("done_x_ready",   64'(bus.x_ready_o),   64'd0);
  endtask

  // With res_ready high, DONE lasts one cycle and IDLE follows.
  task automatic back_to_idle();
    tick();
    chk("idle_x_ready",   64'(bus.x_ready_o),   64'd1);
    chk("idle_res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("idle_cfg_ready", 64'(bus.cfg_ready_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.cfg_start_i = 1'b0;
    bus.cfg_valid_i = 1'b0;
    bus.cfg_data_i  = 8'h00;
    bus.x_valid_i   = 1'b0;
    bus.x_i         = 4'h0;
    bus.res_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) tbl_exp[i] = 8'h00;

    // Reset asserted mid-clock.
    tick();
    tick();
    #3 rst = 1'b0;
    #2 chk_reset_outputs("rst");
    tick();
    #3 rst = 1'b1;
    tick();

    // Sample offered in CFG is not accepted.
    bus.x_valid_i = 1'b1;
    bus.x_i       = 4'hF;
    tick();
    tick();
    chk("cfg_x_ready", 64'(bus.x_ready_o), 64'd0);
    chk("cfg_nen",     64'(bus.nen_o),     64'd0);
    bus.x_valid_i = 1'b0;
    tick();
    chk("cfg_ready_pre", 64'(bus.cfg_ready_o), 64'd1);

    // Full load, full input.
    load(1'b0, 1'b0);
    run_sample(4'b1111, RES_FULL, 0);
    back_to_idle();

    // Partial input.
    run_sample(4'b0101, RES_PART, 0);
    back_to_idle();

    // Backpressure with the next sample waiting.
    bus.res_ready_i = 1'b0;
    run_sample(4'b1111, RES_FULL, 0);
    bus.x_valid_i = 1'b1;
    bus.x_i       = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_res_valid", 64'(bus.res_valid_o), 64'd1);
      chk("bp_res",       64'(bus.res_o),       64'(RES_FULL));
      chk("bp_x_ready",   64'(bus.x_ready_o),   64'd0);
      chk("bp_nen",       64'(bus.nen_o),       64'd0);
    end
    bus.res_ready_i = 1'b1;
    tick();
    chk("bp_release_x_ready", 64'(bus.x_ready_o), 64'd1);
    run_sample(4'b0101, RES_PART, 0);
    back_to_idle();

    // Reload with gaps after a restart from IDLE.
    bus.cfg_start_i = 1'b1;
    tick();
    bus.cfg_start_i = 1'b0;
    chk("restart_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    chk("restart_x_ready",   64'(bus.x_ready_o),   64'd0);
    load(1'b0, 1'b1);
    run_sample(4'b1111, RES_FULL, 0);
    back_to_idle();

    // cfg_start during RUN is ignored.
    run_sample(4'b1111, RES_FULL, 2);
    back_to_idle();

    // cfg_start together with a sample in IDLE: the sample wins.
    run_sample(4'b0101, RES_PART, 1);
    back_to_idle();

    // Reset in RUN cycle 2.
    bus.x_valid_i = 1'b1;
    bus.x_i       = 4'b1111;
    tick();
    bus.x_valid_i = 1'b0;
    tick();
    chk("pre_rst_nen", 64'(bus.nen_o), 64'd1);
    #3 rst = 1'b0;
    #2 chk_reset_outputs("rst_run");
    tick();
    #3 rst = 1'b1;
    tick();
    chk("post_rst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    bus.x_valid_i = 1'b1;
    tick();
    chk("post_rst_x_refused", 64'(bus.nen_o), 64'd0);
    bus.x_valid_i = 1'b0;
    load(1'b1, 1'b0);
    run_sample(4'b1111, 40'd0, 0);
    back_to_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
